// File: rtl/lsu_mem_access.sv
// lsu_mem_access: load/store memory-access stage.
// Accepts one request from execute, runs a req/ack transaction with data
// memory, stalls the pipeline while it is outstanding, and hands load data
// (raw word, byte offset, funct3) to the downstream load-data converter.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned half/word
// accesses in IDLE instead of issuing them with the low address bits ignored).
module lsu_mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        ld_valid,
  output logic [31:0] ld_raw,
  output logic [1:0]  ld_offset,
  output logic [2:0]  ld_format,
  output logic        st_done,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        is_store_q, is_store_d;

  logic        busy_d, mem_req_d, mem_we_d;
  logic [31:0] mem_addr_d, mem_wdata_d;
  logic [3:0]  mem_be_d;
  logic        ld_valid_d, st_done_d, bus_err_d;
  logic [31:0] ld_raw_d;
  logic [1:0]  ld_offset_d;
  logic [2:0]  ld_format_d;

  logic [1:0]  off;
  logic        fmt_ok;
  logic        misalign;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [16:0] cnt_inc;

  assign off     = req_addr[1:0];
  assign cnt_inc = {1'b0, cnt_q} + 17'd1;

  // Decode the incoming request: legality, lane enables and replicated data.
  always_comb begin
    fmt_ok     = 1'b0;
    misalign   = 1'b0;
    be_calc    = 4'b1111;
    wdata_calc = '0;
    if (req_is_store) begin
      fmt_ok = !req_funct3[2] && (req_funct3[1:0] != 2'b11);
    end else begin
      fmt_ok = (req_funct3[1:0] != 2'b11) && !(req_funct3[2] && req_funct3[1]);
    end
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((req_funct3[1:0] == 2'b01) && off[0]) ||
               ((req_funct3[1:0] == 2'b10) && (off != 2'b00));
`else
    misalign = 1'b0;
`endif
    if (req_is_store) begin
      case (req_funct3[1:0])
        2'b00: begin
          be_calc    = 4'b0001 << off;
          wdata_calc = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          be_calc    = off[1] ? 4'b1100 : 4'b0011;
          wdata_calc = {2{req_wdata[15:0]}};
        end
        default: begin
          be_calc    = 4'b1111;
          wdata_calc = req_wdata;
        end
      endcase
    end
  end

  // Next-state and next-output logic; outputs hold unless a transition updates them.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_store_d  = is_store_q;
    busy_d      = busy;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_be_d    = mem_be;
    mem_wdata_d = mem_wdata;
    ld_raw_d    = ld_raw;
    ld_offset_d = ld_offset;
    ld_format_d = ld_format;
    ld_valid_d  = 1'b0;
    st_done_d   = 1'b0;
    bus_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!fmt_ok || misalign) begin
            bus_err_d = 1'b1;
          end else begin
            state_d     = ACCESS;
            cnt_d       = '0;
            is_store_d  = req_is_store;
            busy_d      = 1'b1;
            mem_req_d   = 1'b1;
            mem_we_d    = req_is_store;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_be_d    = be_calc;
            mem_wdata_d = wdata_calc;
            if (!req_is_store) begin
              ld_offset_d = off;
              ld_format_d = req_funct3;
            end
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d    = DONE;
          mem_req_d  = 1'b0;
          busy_d     = 1'b0;
          ld_valid_d = !is_store_q;
          st_done_d  = is_store_q;
          if (!is_store_q) begin
            ld_raw_d = mem_rdata;
          end
        end else begin
          cnt_d = (cnt_q == 16'hffff) ? cnt_q : cnt_inc[15:0];
          // Abort once this unacknowledged cycle would bring the count to the limit.
          if (cnt_inc >= TIMEOUT_LIMIT) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            busy_d    = 1'b0;
            bus_err_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_store_q <= 1'b0;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      ld_valid   <= 1'b0;
      ld_raw     <= '0;
      ld_offset  <= '0;
      ld_format  <= '0;
      st_done    <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_store_q <= is_store_d;
      busy       <= busy_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_be     <= mem_be_d;
      mem_wdata  <= mem_wdata_d;
      ld_valid   <= ld_valid_d;
      ld_raw     <= ld_raw_d;
      ld_offset  <= ld_offset_d;
      ld_format  <= ld_format_d;
      st_done    <= st_done_d;
      bus_err    <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Testbench for lsu_mem_access: directed cases plus randomized transactions
// checked against a lane/size-based reference model.
module tb_lsu_mem_access;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        busy, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        ld_valid;
  logic [31:0] ld_raw;
  logic [1:0]  ld_offset;
  logic [2:0]  ld_format;
  logic        st_done, bus_err;

  int n_checks = 0;
  int n_fail = 0;

  lsu_mem_access #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_is_store(req_is_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ld_valid(ld_valid), .ld_raw(ld_raw), .ld_offset(ld_offset), .ld_format(ld_format),
    .st_done(st_done), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---- reference model -------------------------------------------------
  function automatic int unsigned acc_size(input logic [2:0] f3);
    int unsigned lg;
    lg = int'(f3[1:0]);
    return 1 << lg;
  endfunction

  function automatic bit legal(input logic st, input logic [2:0] f3, input logic [31:0] addr);
    int unsigned v;
    v = int'(f3);
    if (st && !(v == 0 || v == 1 || v == 2)) return 0;
    if (!st && !(v == 0 || v == 1 || v == 2 || v == 4 || v == 5)) return 0;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((addr % acc_size(f3)) != 0) return 0;
`endif
    return 1;
  endfunction

  function automatic logic [3:0] exp_be(input logic st, input logic [2:0] f3, input logic [31:0] addr);
    int unsigned sz, start, o;
    logic [3:0] be;
    if (!st) return 4'hf;
    sz = acc_size(f3);
    o = addr % 4;
    start = (o / sz) * sz;
    be = '0;
    for (int unsigned i = 0; i < 4; i++) be[i] = (i >= start) && (i < start + sz);
    return be;
  endfunction

  function automatic logic [31:0] exp_wd(input logic st, input logic [2:0] f3, input logic [31:0] w);
    int unsigned sz;
    logic [31:0] r;
    if (!st) return 32'h0;
    sz = acc_size(f3);
    r = '0;
    for (int unsigned i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % sz) +: 8];
    return r;
  endfunction

  // One complete request; ack_delay = unacknowledged ACCESS cycles before ack
  // (>= TO means memory never answers).
  task automatic do_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int unsigned ack_delay,
                        input logic [31:0] rd);
    bit acked;
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    step();
    req_valid = 1'b0;
    if (!legal(st, f3, addr)) begin
      check("trap_bus_err", bus_err, 1'b1);
      check("trap_mem_req", mem_req, 1'b0);
      check("trap_busy", busy, 1'b0);
      step();
      check("trap_bus_err_clear", bus_err, 1'b0);
      check("trap_mem_req_after", mem_req, 1'b0);
      return;
    end
    check("acc_mem_req", mem_req, 1'b1);
    check("acc_busy", busy, 1'b1);
    check("acc_mem_addr", mem_addr, {addr[31:2], 2'b00});
    check("acc_mem_be", mem_be, exp_be(st, f3, addr));
    check("acc_mem_we", mem_we, st);
    check("acc_mem_wdata", mem_wdata, exp_wd(st, f3, wd));
    acked = 0;
    for (int unsigned k = 1; k <= TO && !acked; k++) begin
      mem_ack = (k == ack_delay + 1);
      mem_rdata = rd;
      step();
      if (mem_ack) begin
        acked = 1;
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        check("done_busy", busy, 1'b0);
        check("done_mem_req", mem_req, 1'b0);
        check("done_ld_valid", ld_valid, !st);
        check("done_st_done", st_done, st);
        check("done_bus_err", bus_err, 1'b0);
        if (!st) begin
          check("ld_raw", ld_raw, rd);
          check("ld_offset", ld_offset, addr[1:0]);
          check("ld_format", ld_format, f3);
        end
        // a request presented during DONE must be ignored
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check("post_ld_valid", ld_valid, 1'b0);
        check("post_st_done", st_done, 1'b0);
        check("done_ignores_req", busy, 1'b0);
      end else if (k == TO) begin
        check("to_bus_err", bus_err, 1'b1);
        check("to_busy", busy, 1'b0);
        check("to_mem_req", mem_req, 1'b0);
        check("to_ld_valid", ld_valid, 1'b0);
        check("to_st_done", st_done, 1'b0);
        step();
        check("to_bus_err_clear", bus_err, 1'b0);
      end else begin
        check("wait_mem_req", mem_req, 1'b1);
        check("wait_busy", busy, 1'b1);
        check("wait_mem_be", mem_be, exp_be(st, f3, addr));
        check("wait_mem_addr", mem_addr, {addr[31:2], 2'b00});
      end
    end
  endtask

  initial begin
    // reset state
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_be", mem_be, 4'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_ld_raw", ld_raw, 32'h0);
    check("rst_bus_err", bus_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // directed cases
    do_txn(1'b0, 3'b000, 32'h0000_1001, 32'h0, 2, 32'h8192_a3b4);   // LB
    do_txn(1'b1, 3'b000, 32'h0000_2003, 32'h1234_56ab, 0, 32'h0);   // SB
    do_txn(1'b1, 3'b001, 32'h0000_2002, 32'hdead_beef, 1, 32'h0);   // SH hi
    do_txn(1'b1, 3'b001, 32'h0000_2000, 32'hdead_beef, 0, 32'h0);   // SH lo
    do_txn(1'b0, 3'b010, 32'h0000_0040, 32'h0, TO, 32'h0);          // LW timeout
    do_txn(1'b0, 3'b010, 32'h0000_0006, 32'h0, 0, 32'h5555_aaaa);   // LW offset 2
    do_txn(1'b1, 3'b011, 32'h0000_0100, 32'h0, 0, 32'h0);           // bad store f3
    do_txn(1'b1, 3'b100, 32'h0000_0100, 32'h0, 0, 32'h0);           // bad store f3
    do_txn(1'b0, 3'b011, 32'h0000_0100, 32'h0, 0, 32'h0);           // bad load f3
    do_txn(1'b0, 3'b110, 32'h0000_0100, 32'h0, 0, 32'h0);           // bad load f3
    do_txn(1'b0, 3'b101, 32'h0000_0102, 32'h0, 3, 32'hcafe_f00d);   // LHU, ack on last cycle

    // mem_ack outside ACCESS has no effect
    mem_ack = 1'b1;
    step();
    step();
    mem_ack = 1'b0;
    check("idle_ack_busy", busy, 1'b0);
    check("idle_ack_ld_valid", ld_valid, 1'b0);
    check("idle_ack_st_done", st_done, 1'b0);

    // reset in the middle of a store
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h0000_3000; req_wdata = 32'h0bad_f00d;
    step();
    req_valid = 1'b0;
    check("mid_mem_req", mem_req, 1'b1);
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_mem_req", mem_req, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_mem_be", mem_be, 4'h0);
    check("midrst_mem_we", mem_we, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    do_txn(1'b0, 3'b010, 32'h0000_0010, 32'h0, 1, 32'h0102_0304);   // LW after reset

    // randomized transactions
    for (int n = 0; n < 60; n++) begin
      do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom_range(0, TO), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
- Memory-access stage that sits directly upstream of the load-data converter. It takes one load/store request from the execute stage and runs a request/acknowledge transaction with data memory.
- For stores, it produces a word-aligned address, byte enables and lane-replicated write data.
- For loads, it hands the raw memory word, byte offset and funct3 format to the converter.
- It stalls the pipeline while a transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles to wait for mem_ack before aborting with bus_err; valid range 1..65535.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  1  execute stage presents an access this cycle
- req_is_store  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  input  32  effective byte address
- req_wdata  input  32  store source register value
- busy  output  1  stall to pipeline; high while a request is held
- mem_req  output  1  memory request strobe
- mem_we  output  1  write enable
- mem_addr  output  32  word address, {req_addr[31:2],2'b00}
- mem_be  output  4  byte enables
- mem_wdata  output  32  lane-aligned store data
- mem_ack  input  1  memory completed the access; mem_rdata is valid when a load is acknowledged
- mem_rdata  input  32  read word
- ld_valid  output  1  one-cycle pulse; ld_* outputs valid
- ld_raw  output  32  captured mem_rdata
- ld_offset  output  2  captured req_addr[1:0]
- ld_format  output  3  captured funct3
- st_done  output  1  one-cycle pulse on store completion
- bus_err  output  1  one-cycle pulse on timeout or misalignment trap

Behaviour:
- Reset: state=IDLE. All outputs are 0: busy, mem_req, mem_we, mem_addr, mem_be, mem_wdata, ld_valid, ld_raw, ld_offset, ld_format, st_done, bus_err. The timeout counter is 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - On req_valid, capture all req_* fields and compute mem_addr, mem_be, mem_wdata, mem_we.
  - Next cycle: state=ACCESS, mem_req=1, busy=1.
  - busy rises in the cycle after req_valid is sampled.
  - The pipeline holds req_* stable until busy falls.
- ACCESS:
  - mem_req and all mem_* outputs are held constant until mem_ack.
  - The counter increments each cycle without ack.
  - On mem_ack: mem_req=0. For a load, ld_raw<=mem_rdata. Next state DONE.
  - If the counter reaches TIMEOUT_CYCLES without ack: mem_req=0, bus_err pulses 1 cycle, state returns to IDLE, busy=0, no ld_valid/st_done.
- DONE (1 cycle): ld_valid=1 (load) or st_done=1 (store); busy=0. Next state IDLE.
  - req_valid is ignored in DONE.
  - Minimum load latency is 3 cycles from req_valid to ld_valid when mem_ack comes on the first ACCESS cycle.
- Byte enables and write data for an offset o=req_addr[1:0]:
  - SB: be=4'b0001<<o; wdata={4{req_wdata[7:0]}}.
  - SH: be = o[1] ? 4'b1100 : 4'b0011; wdata={2{req_wdata[15:0]}}.
  - SW: be=4'b1111; wdata=req_wdata.
  - Loads: be=4'b1111; mem_we=0; mem_wdata=0.
- Invalid funct3: store funct3 with bit2=1 or value 011; load funct3 of 011, 110 or 111. Treated like a misalignment (bus_err, no memory request).
- The counter clears on every entry to ACCESS; it is 16 bits wide and saturates.
- mem_ack is ignored outside ACCESS.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs cleared. The memory side must tolerate mem_req dropping without ack.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned access means halfword with o[0]=1, or word with o!=0.
  - It is detected in IDLE: no mem_req is issued, bus_err pulses in the cycle after req_valid, busy stays 0, state stays IDLE.
- Undefined:
  - The access proceeds with the low address bits ignored.
  - SH uses the o[1] rule above; SW uses be=4'b1111.
  - Loads pass the raw offset to ld_offset unchanged; the downstream converter resolves it.

Test Plan:
- LB at 0x0000_1001, memory acks after 2 cycles with 0x8192_a3b4 -> mem_addr=0x0000_1000, mem_be=4'b1111, mem_we=0. busy high 3 cycles. ld_valid pulse with ld_raw=0x8192_a3b4, ld_offset=2'b01, ld_format=3'b000.
- SB at 0x0000_2003, req_wdata=0x1234_56ab -> mem_be=4'b1000, mem_wdata=0xabab_abab, mem_we=1, st_done pulse after ack.
- SH at 0x0000_2002, req_wdata=0xdead_beef -> mem_be=4'b1100, mem_wdata=0xbeef_beef. Same with addr 0x0000_2000 -> mem_be=4'b0011.
- LW with no mem_ack and TIMEOUT_CYCLES=4 -> mem_req high 4 cycles, then bus_err pulse; busy=0; no ld_valid.
- rst_n pulled low during ACCESS of SW -> mem_req, busy and mem_be are 0 immediately. After release, a new LW at 0x10 completes normally.
- With LSU_MISALIGN_TRAP_EN, LW at 0x0000_0006 -> bus_err one cycle after req_valid, mem_req never asserts. Without the macro -> mem_addr=0x0000_0004, ld_offset=2'b10.
